// File: rtl/pa_pkg.sv
// Shared types and sizing for the privacy-amplification sequencer.
// Widths, FSM encoding and round-counter width live here.
package pa_pkg;

  localparam int N     = 128;
  localparam int M_MAX = 64;
  localparam int CNT_W = $clog2(M_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/pa_parity.sv
// XOR reduction of the AND-stage result.
// Purely combinational; one parity bit per capture.
module pa_parity #(
  parameter int N = pa_pkg::N
) (
  input  logic [N-1:0] data_i,
  output logic         par_o
);

  // Fold all bits into one parity bit.
  assign par_o = ^data_i;

endmodule

// File: rtl/pa_sequencer.sv
// Run controller for the CA/AND privacy-amplification datapath.
// Loads the CA, steps it L times, and shifts one parity bit per step.
module pa_sequencer
  import pa_pkg::*;
#(
  parameter int N     = pa_pkg::N,
  parameter int M_MAX = pa_pkg::M_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     key_in,
  input  logic [N-1:0]     seed_in,
  input  logic [6:0]       out_len,
  input  logic             abort,
  output logic [N-1:0]     xsmy,
  output logic [N-1:0]     ca_seed,
  output logic             ca_load,
  output logic             ca_step,
  output logic             ca_en,
  input  logic [N-1:0]     caout,
  output logic [M_MAX-1:0] hash_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(M_MAX + 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    key_q;
  logic [N-1:0]    seed_q;
  logic [M_MAX-1:0] hash_q;
  logic            ca_load_q;
  logic            ca_step_q;
  logic            ca_en_q;
  logic            cap_vld_q;
  logic            done_q;
  logic            err_q;
  logic            par;
  logic            len_ok;

  pa_parity #(
    .N(N)
  ) u_parity (
    .data_i(caout),
    .par_o (par)
  );

  assign len_ok = (out_len != 7'd0) &&
                  (int'(out_len) <= M_MAX);

  // FSM, round counter, strobes and result shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      key_q     <= '0;
      seed_q    <= '0;
      hash_q    <= '0;
      ca_load_q <= 1'b0;
      ca_step_q <= 1'b0;
      ca_en_q   <= 1'b0;
      cap_vld_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ca_load_q <= 1'b0;
      ca_step_q <= 1'b0;
      ca_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cap_vld_q <= ca_en_q;
      if (cap_vld_q) begin
        hash_q <= {hash_q[M_MAX-2:0], par};
      end
      if (abort && (state_q != S_IDLE)) begin
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        cap_vld_q <= 1'b0;
        hash_q    <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              if (len_ok) begin
                key_q     <= key_in;
                seed_q    <= seed_in;
                cnt_q     <= CW'(out_len);
                hash_q    <= '0;
                ca_load_q <= 1'b1;
                state_q   <= S_LOAD;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            ca_en_q   <= 1'b1;
            ca_step_q <= 1'b1;
            state_q   <= S_RUN;
          end
          S_RUN: begin
            if (cnt_q == CW'(1)) begin
              cnt_q   <= '0;
              state_q <= S_DRAIN;
            end else begin
              cnt_q     <= cnt_q - CW'(1);
              ca_en_q   <= 1'b1;
              ca_step_q <= 1'b1;
            end
          end
          S_DRAIN: begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign xsmy     = key_q;
  assign ca_seed  = seed_q;
  assign ca_load  = ca_load_q;
  assign ca_step  = ca_step_q;
  assign ca_en    = ca_en_q;
  assign hash_out = hash_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/pa_sequencer.md
PA_SEQUENCER -- requirements
Module: pa_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 128, meaning reconciled-key and CA-state width in bits.
REQ-002 The block SHALL have parameter M_MAX, default 64, meaning the maximum final-key length in bits.
REQ-003 Port clk, input, 1 bit: system clock, rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port start, input, 1 bit: run request, sampled only in IDLE.
REQ-006 Port key_in, input, N bits: reconciled key, latched at start acceptance.
REQ-007 Port seed_in, input, N bits: CA seed, latched at start acceptance.
REQ-008 Port out_len, input, 7 bits: final-key length L, latched at start acceptance.
REQ-009 Port abort, input, 1 bit: cancels an active run.
REQ-010 Port xsmy, output, N bits: latched key driven to the AND stage.
REQ-011 Port ca_seed, output, N bits: latched seed driven to the CA.
REQ-012 Port ca_load, output, 1 bit: CA loads ca_seed.
REQ-013 Port ca_step, output, 1 bit: CA advances one generation.
REQ-014 Port ca_en, output, 1 bit: enable to the AND stage.
REQ-015 Port caout, input, N bits: registered AND-stage result.
REQ-016 Port hash_out, output, M_MAX bits: final key.
REQ-017 Port busy, output, 1 bit: high in every state except IDLE.
REQ-018 Port done, output, 1 bit: one-cycle pulse when hash_out is valid.
REQ-019 Port err, output, 1 bit: one-cycle pulse on a rejected start.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, RUN, DRAIN and DONE.
REQ-021 In IDLE, start with 1<=out_len<=M_MAX SHALL latch key_in, seed_in and out_len, clear hash_out, and move to LOAD.
REQ-022 In IDLE, start with out_len=0 or out_len>M_MAX SHALL pulse err the next cycle and remain in IDLE.
REQ-023 LOAD SHALL last 1 cycle with ca_load=1, then move to RUN.
REQ-024 RUN SHALL last exactly L cycles with ca_en=1 and ca_step=1, counted by a round counter of width clog2(M_MAX+1).
REQ-025 cap_vld SHALL be ca_en delayed one cycle, and each cap_vld cycle SHALL shift hash_out <= {hash_out[M_MAX-2:0], ^caout}.
REQ-026 The controller SHALL NOT use the AND stage's own enable flag to time captures.
REQ-027 After the last RUN cycle the FSM SHALL enter DRAIN for 1 cycle, during which the final capture occurs, then DONE.
REQ-028 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-029 hash_out SHALL hold its value until the next accepted start.
REQ-030 Timing SHALL be: start sampled at cycle 0; LOAD at cycle 1; RUN at cycles 2..L+1; captures at cycles 3..L+2; done at cycle L+3.
REQ-031 The result SHALL be MSB-first within the low L bits of hash_out, with upper bits 0.
REQ-032 start while busy SHALL be ignored with no err.
REQ-033 abort in any non-IDLE state SHALL move the FSM to IDLE next cycle, deassert ca_en, ca_step and ca_load, suppress done, and clear hash_out.
REQ-034 abort SHALL take priority over all transitions, and abort in IDLE SHALL have no effect.
REQ-035 start and abort high together in IDLE SHALL give abort priority, so start is not accepted.
REQ-036 ca_en, ca_step, ca_load, done and err SHALL be registered outputs.

Reset
REQ-037 On rst_n low, the FSM SHALL be IDLE; the counter, xsmy, ca_seed and hash_out SHALL be 0; all strobes and busy SHALL be 0.
REQ-038 Reset mid-run SHALL discard the run, with no done pulse after release.

Structure
REQ-039 Package pa_pkg SHALL hold N, M_MAX, the FSM state enum and the counter-width constant.
REQ-040 A sub-module pa_parity (N-bit XOR reduce, combinational) SHALL be used, and the AND stage and CA SHALL remain external.

Verification
REQ-041 L=1, bench caout=all-ones with N=128 (even parity) -> done at cycle 4, hash_out=0.
REQ-042 L=4, bench caout parities 1,0,1,1 on captures -> hash_out=0x...000B, done at cycle 7, ca_en high for exactly 4 cycles.
REQ-043 out_len=0, then out_len=65 -> err pulse each time, busy stays 0, hash_out unchanged.
REQ-044 L=64, abort asserted at cycle 20 -> IDLE at cycle 21, no done, hash_out=0, strobes low.
REQ-045 start re-pulsed during RUN (L=8) -> ignored, single done at cycle 11.
REQ-046 rst_n low at cycle 5 of an L=16 run -> all outputs 0 immediately, no done after release.
